// File: rtl/btn_debouncer.sv
// Debouncer for one active-low push button. It produces a clean level plus
// single-cycle press, release and auto-repeat pulses.
module btn_debouncer #(
   parameter int DEBOUNCE_CNT = 120000,
   parameter int REPEAT_DLY   = 3000000,
   parameter int REPEAT_PER   = 600000,
   parameter int CNT_W        = 22
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic switch_input,
   output logic level,
   output logic trans_dn,
   output logic trans_up,
   output logic repeat_pulse  // "repeat" is a reserved word in SystemVerilog
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'((REPEAT_PER > 0) ? REPEAT_PER - 1 : 0);
   localparam bit               RPT_EN   = (REPEAT_DLY != 0);

   logic             sync_q1;
   logic             sync_q2;
   state_t           state;
   logic [CNT_W-1:0] db_cnt;
   logic [CNT_W-1:0] rpt_cnt;
   logic             rpt_first;
   logic [CNT_W-1:0] rpt_thresh;
   logic             s_released;

   // Pin idles high when released, so both flops reset to 1 and no false press follows reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= switch_input;
         sync_q2 <= sync_q1;
      end
   end

   assign s_released = sync_q2;
   assign rpt_thresh = rpt_first ? DLY_LAST : PER_LAST;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         db_cnt       <= '0;
         rpt_cnt      <= '0;
         rpt_first    <= 1'b1;
         level        <= 1'b0;
         trans_dn     <= 1'b0;
         trans_up     <= 1'b0;
         repeat_pulse <= 1'b0;
      end else begin
         trans_dn     <= 1'b0;
         trans_up     <= 1'b0;
         repeat_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (!s_released) begin
                  state  <= PRESS_WAIT;
                  db_cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (s_released) begin
                  state  <= IDLE;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state     <= PRESSED;
                  db_cnt    <= '0;
                  level     <= 1'b1;
                  trans_dn  <= 1'b1;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               // Leaving on a release sample takes priority over a due repeat pulse.
               if (s_released) begin
                  state  <= RELEASE_WAIT;
                  db_cnt <= '0;
               end else if (RPT_EN) begin
                  if (rpt_cnt == rpt_thresh) begin
                     repeat_pulse <= 1'b1;
                     rpt_cnt      <= '0;
                     rpt_first    <= 1'b0;
                  end else begin
                     rpt_cnt <= rpt_cnt + CNT_W'(1);
                  end
               end
            end
            RELEASE_WAIT: begin
               if (!s_released) begin
                  state  <= PRESSED;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state    <= IDLE;
                  db_cnt   <= '0;
                  level    <= 1'b0;
                  trans_up <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + CNT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               db_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer. Expected pulses are queued with their due
// cycle and compared every cycle on the falling clock edge.
module tb_btn_debouncer;

   localparam int DB  = 4;
   localparam int DLY = 10;
   localparam int PER = 3;

   localparam logic [2:0] P_DN  = 3'b100;
   localparam logic [2:0] P_UP  = 3'b010;
   localparam logic [2:0] P_RPT = 3'b001;

   logic CLK;
   logic RST_N;
   logic switch_input;
   logic level;
   logic trans_dn;
   logic trans_up;
   logic repeat_pulse;

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        exp_level = 1'b0;
   logic [31:0] exp_q[$];

   btn_debouncer #(
      .DEBOUNCE_CNT (DB),
      .REPEAT_DLY   (DLY),
      .REPEAT_PER   (PER),
      .CNT_W        (8)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .switch_input (switch_input),
      .level        (level),
      .trans_dn     (trans_dn),
      .trans_up     (trans_up),
      .repeat_pulse (repeat_pulse)
   );

   // clock / cycle counter: at the falling edge after rising edge k, cyc == k
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic exp_push(input int due, input logic [2:0] pulses);
      logic [31:0] e;
      e = {due[28:0], pulses};
      exp_q.push_back(e);
   endtask

   task automatic check_cycle();
      logic [31:0] head;
      logic [2:0]  exp_p;
      logic [2:0]  obs_p;
      exp_p = 3'b000;
      if (exp_q.size() > 0) begin
         head = exp_q[0];
         if (head[31:3] == cyc[28:0]) begin
            void'(exp_q.pop_front());
            exp_p = head[2:0];
         end
      end
      if (!RST_N)        exp_level = 1'b0;
      else if (exp_p[2]) exp_level = 1'b1;
      else if (exp_p[1]) exp_level = 1'b0;
      obs_p = {trans_dn, trans_up, repeat_pulse};
      checks++;
      assert (obs_p === exp_p) else begin
         failures++;
         $error("FAIL pulses cyc=%0d observed(dn,up,rpt)=%b expected=%b", cyc, obs_p, exp_p);
      end
      checks++;
      assert (level === exp_level) else begin
         failures++;
         $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, level, exp_level);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         check_cycle();
      end
   endtask

   initial begin
      int t;
      int w;
      int y;
      RST_N        = 1'b0;
      switch_input = 1'b1;

      // reset, then released pin held for 50 cycles
      tick(3);
      RST_N = 1'b1;
      tick(50);

      // clean press with repeats, a short release bounce, then a real release
      t = cyc;
      switch_input = 1'b0;
      exp_push(t + 7, P_DN);
      exp_push(t + 17, P_RPT);
      exp_push(t + 20, P_RPT);
      exp_push(t + 23, P_RPT);
      exp_push(t + 26, P_RPT);
      tick(24);
      switch_input = 1'b1;
      exp_push(t + 32, P_RPT);
      exp_push(t + 35, P_RPT);
      tick(2);
      switch_input = 1'b0;
      tick(9);
      switch_input = 1'b1;
      exp_push(t + 42, P_UP);
      tick(20);

      // press bounce of 3 cycles: rejected
      switch_input = 1'b0;
      tick(3);
      switch_input = 1'b1;
      tick(20);

      // one-sample glitch restarts the count, then a short press without repeats
      w = cyc;
      switch_input = 1'b0;
      tick(3);
      switch_input = 1'b1;
      tick(1);
      switch_input = 1'b0;
      exp_push(w + 11, P_DN);
      tick(8);
      switch_input = 1'b1;
      exp_push(w + 19, P_UP);
      tick(20);

      // reset during PRESS_WAIT with the button held through reset release
      switch_input = 1'b0;
      tick(4);
      #2 RST_N = 1'b0;
      tick(3);
      #2 RST_N = 1'b1;
      y = cyc;
      exp_push(y + 7, P_DN);
      tick(8);
      switch_input = 1'b1;
      exp_push(y + 15, P_UP);
      tick(20);

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
